// File: rtl/main_fsm_ctrl.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/writeback and drives datapath selects.
// Optional illegal-opcode trap state enabled by defining ILLEGAL_OP_TRAP_EN.
module main_fsm_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALUop,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] state_o,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
        , S_TRAP   = 4'd11
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q, state_d;
    logic   illegal_d;

    logic pc_update, branch, ir_write_raw, reg_write_raw, mem_write_raw;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
`else
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_op_q, illegal_op_d;
    assign illegal_op_d = illegal_op_q | illegal_d;
    assign illegal_op   = illegal_op_q;
`else
    assign illegal_op   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= state_t'(RESET_STATE);
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op_q <= illegal_op_d;
`endif
        end
    end

    // Outputs are a pure decode of the state register; only FETCH and BEQ look at inputs.
    always_comb begin
        ALUop         = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        AdrSrc        = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUop   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUop   = 2'b10;
            end
            S_ALUWB:    reg_write_raw = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUop   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks every architectural write so an aborted instruction leaves no trace.
    assign IRWrite  = ir_write_raw & ~rst;
    assign PCWrite  = (pc_update | (branch & zero)) & ~rst;
    assign RegWrite = reg_write_raw & ~rst;
    assign MemWrite = mem_write_raw & ~rst;
    assign state_o  = state_q;

endmodule

// File: tb/tb_main_fsm_ctrl.sv
// Self-checking bench for main_fsm_ctrl: table of instructions plus hand sequences for stalls and reset.
module tb_main_fsm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUop, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op;
    logic [3:0] state_o;

    main_fsm_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .state_o(state_o), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4;
    localparam logic [3:0] S_MW = 4'd5, S_EXR = 4'd6, S_EXI = 4'd7, S_WB = 4'd8;
    localparam logic [3:0] S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] aluop, srca, srcb, res;
        logic       adr, irw, pcw, rw, mw;
    } obs_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       zero;
        int         n;
        logic [23:0] seq;
    } vec_t;

    obs_t sb_q[$];
    obs_t act;
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   mw_seen = 0;

    assign act = {state_o, ALUop, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite};

    // Reference outputs per state, written straight from the state/output listing.
    function automatic obs_t model(logic [3:0] st, logic mr, logic z);
        obs_t o = '0;
        o.st = st;
        case (st)
            S_F:   begin o.srcb = 2'b10; o.res = 2'b10; o.irw = mr; o.pcw = mr; end
            S_D:   begin o.srca = 2'b01; o.srcb = 2'b01; end
            S_MA:  begin o.srca = 2'b10; o.srcb = 2'b01; end
            S_MR:  o.adr = 1'b1;
            S_MWB: begin o.res = 2'b01; o.rw = 1'b1; end
            S_MW:  begin o.adr = 1'b1; o.mw = 1'b1; end
            S_EXR: begin o.srca = 2'b10; o.aluop = 2'b10; end
            S_EXI: begin o.srca = 2'b10; o.srcb = 2'b01; o.aluop = 2'b10; end
            S_WB:  o.rw = 1'b1;
            S_BEQ: begin o.srca = 2'b10; o.aluop = 2'b01; o.pcw = z; end
            S_JAL: begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check_obs(input string name);
        obs_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = sb_q.pop_front();
            if (MemWrite) mw_seen++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", name, act, act.st, e, e.st);
            end
        end
    endtask

    task automatic check_now(input obs_t e, input string name);
        sb_q.push_back(e);
        check_obs(name);
    endtask

    task automatic check_bit(input logic a, input logic e, input string name);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    // One clock: drive inputs, queue expectation, compare at negedge, advance past posedge.
    task automatic step(input logic [3:0] st, input logic [6:0] o, input logic z, input logic mr,
                        input string name);
        op = o; zero = z; mem_ready = mr;
        sb_q.push_back(model(st, mr, z));
        @(negedge clk);
        check_obs(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"lw",      7'b0000011, 1'b0, 5, {S_MWB, S_MR, S_MA, S_D, S_F}};
        vecs[1] = '{"sw",      7'b0100011, 1'b0, 4, {S_MW, S_MA, S_D, S_F}};
        vecs[2] = '{"rtype",   7'b0110011, 1'b0, 4, {S_WB, S_EXR, S_D, S_F}};
        vecs[3] = '{"itype",   7'b0010011, 1'b0, 4, {S_WB, S_EXI, S_D, S_F}};
        vecs[4] = '{"beq_z1",  7'b1100011, 1'b1, 3, {S_BEQ, S_D, S_F}};
        vecs[5] = '{"beq_z0",  7'b1100011, 1'b0, 3, {S_BEQ, S_D, S_F}};
        vecs[6] = '{"jal",     7'b1101111, 1'b0, 4, {S_WB, S_JAL, S_D, S_F}};
        vecs[7] = '{"illegal", 7'b1111111, 1'b0, 2, {S_D, S_F}};

        rst = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check_now(model(S_F, 1'b0, 1'b0), "reset_state");
        check_bit(illegal_op, 1'b0, "reset_illegal");
        @(posedge clk);
        #1 rst = 1'b0;

`ifndef ILLEGAL_OP_TRAP_EN
        for (int v = 0; v < 8; v++)
            for (int i = 0; i < vecs[v].n; i++)
                step(vecs[v].seq[4*i +: 4], vecs[v].op, vecs[v].zero, 1'b1, vecs[v].name);
        check_bit(illegal_op, 1'b0, "illegal_tied0");
        step(S_F, 7'b0110011, 1'b0, 1'b1, "illegal_back_fetch");
        step(S_D, 7'b0110011, 1'b0, 1'b1, "rtype2");
        step(S_EXR, 7'b0110011, 1'b0, 1'b1, "rtype2");
        step(S_WB, 7'b0110011, 1'b0, 1'b1, "rtype2");
`else
        for (int v = 0; v < 7; v++)
            for (int i = 0; i < vecs[v].n; i++)
                step(vecs[v].seq[4*i +: 4], vecs[v].op, vecs[v].zero, 1'b1, vecs[v].name);
`endif

        // fetch stall, mem_ready ignored in DECODE, then async reset during EXECR
        step(S_F, 7'b0110011, 1'b0, 1'b0, "fetch_stall");
        step(S_F, 7'b0110011, 1'b0, 1'b1, "fetch_go");
        step(S_D, 7'b0110011, 1'b0, 1'b0, "decode_ignores_mr");
        op = 7'b0110011; mem_ready = 1'b1;
        check_now(model(S_EXR, 1'b1, 1'b0), "in_execr");
        rst = 1'b1;
        #1;
        check_now(model(S_F, 1'b0, 1'b0), "rst_async");
        @(negedge clk);
        check_now(model(S_F, 1'b0, 1'b0), "rst_held_negedge");
        @(posedge clk);
        #1;
        check_now(model(S_F, 1'b0, 1'b0), "rst_held_posedge");
        rst = 1'b0;
        step(S_F, 7'b0110011, 1'b0, 1'b1, "post_rst_fetch");
        step(S_D, 7'b0110011, 1'b0, 1'b1, "post_rst_r");
        step(S_EXR, 7'b0110011, 1'b0, 1'b1, "post_rst_r");
        step(S_WB, 7'b0110011, 1'b0, 1'b1, "post_rst_r");

        // store with three wait cycles in MEMWRITE
        mw_seen = 0;
        step(S_F, 7'b0100011, 1'b0, 1'b1, "sw_stall");
        step(S_D, 7'b0100011, 1'b0, 1'b1, "sw_stall");
        step(S_MA, 7'b0100011, 1'b0, 1'b0, "sw_stall_ma_ignores_mr");
        step(S_MW, 7'b0100011, 1'b0, 1'b0, "sw_wait1");
        step(S_MW, 7'b0100011, 1'b0, 1'b0, "sw_wait2");
        step(S_MW, 7'b0100011, 1'b0, 1'b0, "sw_wait3");
        step(S_MW, 7'b0100011, 1'b0, 1'b1, "sw_done");
        checks++;
        if (mw_seen != 4) begin
            errors++;
            $display("FAIL sw_memwrite_cycles: got %0d expected 4", mw_seen);
        end

        // load with one wait in MEMREAD
        step(S_F, 7'b0000011, 1'b0, 1'b1, "lw_stall");
        step(S_D, 7'b0000011, 1'b0, 1'b1, "lw_stall");
        step(S_MA, 7'b0000011, 1'b0, 1'b1, "lw_stall");
        step(S_MR, 7'b0000011, 1'b0, 1'b0, "lw_wait");
        step(S_MR, 7'b0000011, 1'b0, 1'b1, "lw_done");
        step(S_MWB, 7'b0000011, 1'b0, 1'b0, "lw_wb_ignores_mr");

        // taken branch with mem_ready low outside FETCH
        step(S_F, 7'b1100011, 1'b1, 1'b1, "beq_mr0");
        step(S_D, 7'b1100011, 1'b1, 1'b0, "beq_mr0");
        step(S_BEQ, 7'b1100011, 1'b1, 1'b0, "beq_mr0");
        step(S_F, 7'b0010011, 1'b0, 1'b1, "back_to_fetch");

`ifdef ILLEGAL_OP_TRAP_EN
        step(S_D, 7'b1111111, 1'b0, 1'b1, "trap_decode");
        check_bit(illegal_op, 1'b1, "trap_flag_set");
        step(S_TRAP, 7'b1111111, 1'b0, 1'b1, "trap_hold1");
        step(S_TRAP, 7'b0110011, 1'b0, 1'b1, "trap_hold2");
        step(S_TRAP, 7'b0110011, 1'b0, 1'b1, "trap_hold3");
        check_bit(illegal_op, 1'b1, "trap_flag_sticky");
        rst = 1'b1;
        #1;
        check_bit(illegal_op, 1'b0, "trap_flag_cleared");
        @(posedge clk);
        #1 rst = 1'b0;
        step(S_F, 7'b0110011, 1'b0, 1'b1, "trap_exit_fetch");
`endif

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
